// File: rtl/axis_decimator.sv
// AXI4-Stream nearest-neighbour video downscaler.
// Drops source pixels/lines with DDA accumulators; fsync-framed, tuser=SOF, tlast=EOL.
module axis_decimator #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_SW_WIDTH    = 10,
    parameter int C_SH_WIDTH    = 10,
    parameter int C_MW_WIDTH    = 10,
    parameter int C_MH_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fsync,
    input  logic [C_SW_WIDTH-1:0]    s_width,
    input  logic [C_SH_WIDTH-1:0]    s_height,
    input  logic [C_MW_WIDTH-1:0]    m_width,
    input  logic [C_MH_WIDTH-1:0]    m_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        RUN
    } state_t;

    localparam int SW = C_SW_WIDTH;
    localparam int SH = C_SH_WIDTH;
    localparam int MW = C_MW_WIDTH;
    localparam int MH = C_MH_WIDTH;

    localparam logic [SW-1:0] SW_ONE = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SH-1:0] SH_ONE = {{(SH-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] MW_ONE = {{(MW-1){1'b0}}, 1'b1};

    state_t state, state_nx;

    logic [SW-1:0] sw_q;
    logic [SH-1:0] sh_q;
    logic [MW-1:0] mw_q;
    logic [MH-1:0] mh_q;
    logic          cfg_ok;

    logic [SW-1:0] col;
    logic [SH-1:0] row;
    logic [MW-1:0] ocol;
    logic [SW:0]   cacc;
    logic [SH:0]   racc;
    logic          keep_r_q;

    logic          cfg_in;
    logic          acc;
    logic          frame_beat;
    logic          sof;
    logic [SW-1:0] col_e;
    logic [SH-1:0] row_e;
    logic [MW-1:0] ocol_e;
    logic          line_start;
    logic          in_line;
    logic          last_row;
    logic          frame_end;
    logic [SW:0]   sw_x, mw_x, cacc_c, csum, cnext;
    logic [SH:0]   sh_x, mh_x, racc_c, rsum, rnext;
    logic          keep_c, keep_r_new, keep_r, keep;

    // Configuration check on the live ports, captured at fsync.
    assign cfg_in = (s_width != '0) && (s_height != '0) &&
                    (m_width != '0) && (m_height != '0) &&
                    ({{(SW+1-MW){1'b0}}, m_width} <= {1'b0, s_width}) &&
                    ({{(SH+1-MH){1'b0}}, m_height} <= {1'b0, s_height});

    assign s_axis_tready = (state != IDLE) & (~m_axis_tvalid | m_axis_tready);
    assign acc           = s_axis_tvalid & s_axis_tready;

    // The SOF beat seen in WAIT_SOF is already pixel (0,0) of the frame.
    assign frame_beat = acc & ~fsync &
                        ((state == RUN) | ((state == WAIT_SOF) & s_axis_tuser));
    assign sof        = frame_beat & s_axis_tuser;

    assign col_e  = sof ? '0 : col;
    assign row_e  = sof ? '0 : row;
    assign ocol_e = sof ? '0 : ocol;

    assign line_start = (col_e == '0);
    assign in_line    = (col_e < sw_q);
    assign last_row   = (row_e == sh_q - SH_ONE);
    assign frame_end  = frame_beat & s_axis_tlast & last_row;

    assign sw_x = {1'b0, sw_q};
    assign mw_x = {{(SW+1-MW){1'b0}}, mw_q};
    assign sh_x = {1'b0, sh_q};
    assign mh_x = {{(SH+1-MH){1'b0}}, mh_q};

    assign cacc_c = line_start ? (sw_x - mw_x) : cacc;
    assign csum   = cacc_c + mw_x;
    assign keep_c = (csum >= sw_x);
    assign cnext  = keep_c ? (csum - sw_x) : csum;

    assign racc_c     = (row_e == '0) ? (sh_x - mh_x) : racc;
    assign rsum       = racc_c + mh_x;
    assign keep_r_new = (rsum >= sh_x);
    assign rnext      = keep_r_new ? (rsum - sh_x) : rsum;

    assign keep_r = line_start ? keep_r_new : keep_r_q;
    assign keep   = frame_beat & in_line & keep_c & keep_r & cfg_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (fsync) begin
            state_nx = WAIT_SOF;
        end else begin
            unique case (state)
                IDLE:     state_nx = IDLE;
                WAIT_SOF: if (sof) state_nx = frame_end ? WAIT_SOF : RUN;
                RUN:      if (frame_end) state_nx = WAIT_SOF;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_q     <= '0;
            sh_q     <= '0;
            mw_q     <= '0;
            mh_q     <= '0;
            cfg_ok   <= 1'b0;
            col      <= '0;
            row      <= '0;
            ocol     <= '0;
            cacc     <= '0;
            racc     <= '0;
            keep_r_q <= 1'b0;
        end else if (fsync) begin
            sw_q     <= s_width;
            sh_q     <= s_height;
            mw_q     <= m_width;
            mh_q     <= m_height;
            cfg_ok   <= cfg_in;
            col      <= '0;
            row      <= '0;
            ocol     <= '0;
            cacc     <= '0;
            racc     <= '0;
            keep_r_q <= 1'b0;
        end else if (frame_beat) begin
            if (line_start) begin
                racc     <= rnext;
                keep_r_q <= keep_r_new;
            end
            if (s_axis_tlast) begin
                col  <= '0;
                ocol <= '0;
                cacc <= '0;
                row  <= frame_end ? '0 : row_e + SH_ONE;
            end else begin
                // col saturates at sw so surplus pixels of a long line stay dropped.
                col  <= in_line ? col_e + SW_ONE : col_e;
                ocol <= keep ? ocol_e + MW_ONE : ocol_e;
                cacc <= in_line ? cnext : cacc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (fsync) begin
            m_axis_tvalid <= 1'b0;
        end else if (keep) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= (row_e == '0) && (col_e == '0);
            m_axis_tlast  <= (ocol_e == mw_q - MW_ONE);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_decimator.sv
// Self-checking bench for axis_decimator against an arithmetic
// nearest-neighbour reference model.
module tb_axis_decimator;

    logic       clk;
    logic       resetn;
    logic       fsync;
    logic [9:0] s_width, s_height, m_width, m_height;
    logic       s_valid, s_user, s_last, s_ready;
    logic [7:0] s_data;
    logic       m_valid, m_user, m_last, m_ready;
    logic [7:0] m_data;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;

    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    logic [7:0] fr[16][16];

    axis_decimator dut (
        .clk           (clk),
        .resetn        (resetn),
        .fsync         (fsync),
        .s_width       (s_width),
        .s_height      (s_height),
        .m_width       (m_width),
        .m_height      (m_height),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tuser  (s_user),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sink ready: 0 always ready, 1 random, 2 stalled.
    initial begin
        m_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 0;
            endcase
        end
    end

    // Output capture and back-pressure check, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && m_valid && m_ready)
                got.push_back({m_user, m_last, m_data});
            if (resetn && m_valid && !m_ready)
                chk("s_ready_hold", {31'b0, s_ready}, 0);
        end
    end

    function automatic bit kidx(int i, int m, int s);
        return (i == 0) || ((i * m) / s != ((i - 1) * m) / s);
    endfunction

    task automatic build_exp(input int sw, input int sh, input int mw, input int mh);
        int k;
        bit first;
        exp_q.delete();
        if (sw == 0 || sh == 0 || mw == 0 || mh == 0 || mw > sw || mh > sh)
            return;
        first = 1;
        for (int r = 0; r < sh; r++) begin
            if (!kidx(r, mh, sh)) continue;
            k = 0;
            for (int c = 0; c < sw; c++) begin
                if (!kidx(c, mw, sw)) continue;
                exp_q.push_back({first, k == mw - 1, fr[r][c]});
                first = 0;
                k++;
            end
        end
    endtask

    task automatic fill(input int pat);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                fr[r][c] = (pat == 0) ? 8'(16 * r + c) : 8'($urandom);
    endtask

    task automatic do_fsync(input int sw, input int sh, input int mw, input int mh);
        s_width  = 10'(sw);
        s_height = 10'(sh);
        m_width  = 10'(mw);
        m_height = 10'(mh);
        fsync = 1;
        @(posedge clk);
        #1;
        fsync = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic u, input logic l,
                             input bit lat);
        int n;
        n = 0;
        s_valid = 1;
        s_data  = d;
        s_user  = u;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            chk("accept_timeout", {31'b0, s_ready}, 1);
            s_valid = 0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 0;
        s_user  = 0;
        s_last  = 0;
        if (lat) begin
            @(negedge clk);
            chk("lat_valid", {31'b0, m_valid}, 1);
            chk("lat_data", {24'b0, m_data}, {24'b0, d});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int sw, input int sh, input bit lat,
                              input bit gaps);
        for (int r = 0; r < sh; r++)
            for (int c = 0; c < sw; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_beat(fr[r][c], r == 0 && c == 0, c == sw - 1, lat);
            end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), {22'b0, got[i]}, {22'b0, exp_q[i]});
    endtask

    task automatic run_frame(input int sw, input int sh, input int mw, input int mh,
                             input int pat, input bit lat, input bit gaps,
                             input string tag);
        fill(pat);
        build_exp(sw, sh, mw, mh);
        got.delete();
        do_fsync(sw, sh, mw, mh);
        send_frame(sw, sh, lat, gaps);
        wait_drain(tag);
    endtask

    initial begin
        resetn = 0; fsync = 0;
        s_valid = 0; s_data = 0; s_user = 0; s_last = 0;
        s_width = 0; s_height = 0; m_width = 0; m_height = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, m_valid}, 0);
        chk("rst_data", {24'b0, m_data}, 0);
        chk("rst_user", {31'b0, m_user}, 0);
        chk("rst_last", {31'b0, m_last}, 0);
        chk("rst_ready", {31'b0, s_ready}, 0);
        resetn = 1;
        @(posedge clk);
        #1;
        chk("idle_ready", {31'b0, s_ready}, 0);

        run_frame(8, 4, 4, 2, 0, 0, 0, "down8x4");
        run_frame(6, 3, 6, 3, 1, 1, 0, "ident");
        rdy_mode = 1;
        run_frame(10, 10, 3, 3, 1, 0, 1, "dec10");
        rdy_mode = 0;
        run_frame(8, 4, 12, 2, 1, 0, 1, "invalid");

        // fsync while an output beat is stalled
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        fill(0);
        do_fsync(8, 4, 4, 2);
        send_beat(fr[0][0], 1, 0, 0);
        @(negedge clk);
        chk("stall_valid", {31'b0, m_valid}, 1);
        @(posedge clk);
        #1;
        s_width = 6; s_height = 3; m_width = 3; m_height = 3;
        fsync = 1;
        @(posedge clk);
        #1;
        fsync = 0;
        @(negedge clk);
        chk("fsync_drop", {31'b0, m_valid}, 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        got.delete();
        for (int i = 0; i < 3; i++)
            send_beat(8'($urandom), 0, i == 2, 0);
        fill(1);
        build_exp(6, 3, 3, 3);
        send_frame(6, 3, 0, 1);
        wait_drain("resync");

        // asynchronous reset mid-frame
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        fill(0);
        do_fsync(8, 4, 4, 2);
        send_beat(fr[0][0], 1, 0, 0);
        @(negedge clk);
        chk("prerst_valid", {31'b0, m_valid}, 1);
        @(posedge clk);
        #1;
        resetn = 0;
        #1;
        chk("arst_valid", {31'b0, m_valid}, 0);
        chk("arst_data", {24'b0, m_data}, 0);
        chk("arst_user", {31'b0, m_user}, 0);
        chk("arst_ready", {31'b0, s_ready}, 0);
        #3;
        resetn = 1;
        rdy_mode = 0;
        s_valid = 1; s_user = 1; s_data = 8'h5a;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_ready", {31'b0, s_ready}, 0);
            chk("postrst_valid", {31'b0, m_valid}, 0);
        end
        @(posedge clk);
        #1;
        s_valid = 0; s_user = 0;
        run_frame(8, 4, 4, 2, 1, 0, 1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_decimator.md
Name: axis_decimator

Overview:
- AXI4-Stream video nearest-neighbour downscaler; the reduction counterpart of the bilinear upscaler in the same video pipeline.
- Drops source pixels and lines so an s_width x s_height frame becomes m_width x m_height, with m ≤ s in each dimension.
- Sits between a sensor/VDMA stream and display or analysis sinks.
- Uses the same fsync-framed, tuser=SOF / tlast=EOL stream convention.

Parameters:
- C_PIXEL_WIDTH, 8, pixel data width.
- C_SW_WIDTH, 10, source width field width.
- C_SH_WIDTH, 10, source height field width.
- C_MW_WIDTH, 10, output width field width; must be ≤ C_SW_WIDTH.
- C_MH_WIDTH, 10, output height field width; must be ≤ C_SH_WIDTH.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- fsync  in  1  frame start pulse; latches sizes and restarts frame state
- s_width  in  C_SW_WIDTH  source pixels per line
- s_height  in  C_SH_WIDTH  source lines per frame
- m_width  in  C_MW_WIDTH  output pixels per line
- m_height  in  C_MH_WIDTH  output lines per frame
- s_axis_tvalid / s_axis_tdata[C_PIXEL_WIDTH] / s_axis_tuser / s_axis_tlast  in  source stream
- s_axis_tready  out  1  source ready
- m_axis_tvalid / m_axis_tdata[C_PIXEL_WIDTH] / m_axis_tuser / m_axis_tlast  out  output stream
- m_axis_tready  in  1  sink ready

Behaviour:
- Reset (async assert, sync release): state IDLE; m_axis_tvalid=0, tdata/tuser/tlast=0; all counters and accumulators 0; s_axis_tready=0.
- Sizes are latched on fsync. A configuration is invalid if any size is 0, m_width>s_width, or m_height>s_height. With an invalid configuration the block consumes and discards all input and never asserts m_axis_tvalid.
- States:
  - IDLE: tready=0. On fsync go to WAIT_SOF.
  - WAIT_SOF: consume input; discard pixels until a beat with tuser=1. That beat is row 0 col 0; go to RUN.
  - RUN: decimate. After the accepted tlast beat of source row s_height-1, go to WAIT_SOF.
- fsync in any state: go to WAIT_SOF next cycle, clear all counters, drop any held output beat (m_axis_tvalid←0).
- Accepted tuser=1 in RUN: treat as a new SOF (resync); the beat is row 0 col 0.
- Ready: outside IDLE, s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational). Discarded beats obey the same rule.
- Column DDA (C_SW_WIDTH+1 bits):
  - At line start cacc = s_width-m_width.
  - Per accepted beat: keep_c = (cacc+m_width ≥ s_width); cacc ← cacc+m_width-(keep_c?s_width:0).
  - Yields exactly m_width kept pixels per s_width-pixel line; col 0 is always kept.
- Row DDA: same arithmetic with heights. It is evaluated once per source line at the line's first beat, giving keep_r for that whole line.
- Pixel kept iff keep_r & keep_c & RUN & config valid.
- Output register: latency 1 cycle from accepted kept beat to m_axis_tvalid=1. Holds until m_axis_tready; load and drain in the same cycle are allowed.
- m_axis_tuser=1 on the first kept pixel of the frame (row 0 col 0).
- m_axis_tlast=1 when the output column counter equals m_width-1. The output column counter resets at each source tlast.
- Line bookkeeping:
  - Source tlast resets cacc and the output column counter, and advances the row counter.
  - A short line (early tlast) yields a short output line with no output tlast.
  - A long line (col ≥ s_width before tlast) discards the extra pixels.
- Source rows beyond s_height-1 without tuser are discarded until a SOF arrives.

Test Plan:
- 8x4→4x2, pixel value = 16·row+col, sink always ready -> output 0,2,4,6 / 32,34,36,38 (source rows 0 and 2 kept, even columns kept); tuser on the first beat; tlast on values 6 and 38.
- 6x3→6x3 identity -> all 18 pixels pass unchanged; latency exactly 1 cycle per beat.
- 10x10→3x3, m_axis_tready toggled 1-0-0-1 randomly -> exactly 9 beats, no loss or duplication; s_axis_tready low whenever held-valid and not ready.
- fsync asserted mid-line while output beat stalled -> m_axis_tvalid drops next cycle; pre-SOF input is discarded; the next frame starts cleanly with tuser.
- m_width=12 > s_width=8 -> input fully consumed, zero output beats.
- Async resetn pulse mid-frame -> outputs zero immediately; fsync is required before any further output.
